// File: rtl/ram_sdp_clr.sv
// Simple dual-port RAM with byte enables, a registered read port and a self-clearing sweep
// that runs after reset or on clr_req. Define RAM_SDP_CLR_BYPASS_EN for write-first collisions.
module ram_sdp_clr #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    wena,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    rena,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    input  logic                    clr_req,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rvalid,
    output logic                    busy
);

    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    typedef enum logic {StClear, StIdle} state_e;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    rvalid_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    req;
    logic                    do_clr;
    logic                    do_wr;
    logic                    do_rd;
    logic [DATA_WIDTH-1:0]   rd_word;

    always_comb begin
        req    = ena && (state_q == StIdle);
        do_clr = req && clr_req;
        do_wr  = req && !clr_req && wena;
        do_rd  = req && !clr_req && rena;
        rd_word = mem[raddr];
`ifdef RAM_SDP_CLR_BYPASS_EN
        // Same-address collision returns the word as it will look after this write.
        if (do_wr && (waddr == raddr)) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (wbe[k]) rd_word[8*k +: 8] = data_in[8*k +: 8];
            end
        end
`endif
    end

    // Array has no reset; only the sweep zeroes it, and never while rst is held.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == StClear)) begin
            mem[clr_cnt_q] <= '0;
        end else if (do_wr) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (wbe[k]) mem[waddr][8*k +: 8] <= data_in[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StClear;
            clr_cnt_q  <= '0;
            data_out_q <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StClear: begin
                    rvalid_q <= 1'b0;
                    if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_q <= StIdle;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + 1'b1;
                    end
                end
                StIdle: begin
                    rvalid_q <= do_rd;
                    if (do_rd) data_out_q <= rd_word;
                    if (do_clr) begin
                        state_q   <= StClear;
                        clr_cnt_q <= '0;
                    end
                end
                default: state_q <= StClear;
            endcase
        end
    end

    assign data_out = data_out_q;
    assign rvalid   = rvalid_q;
    assign busy     = (state_q == StClear);

endmodule
